// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: default sizes, feeder FSM
// state encoding and the operand-pair record carried through the FIFO.
package mac_pkg;

    localparam int unsigned MacDataW = 16;
    localparam int unsigned MacDepth = 8;

    // IDLE: next loaded beat opens a frame; IN_FRAME: a frame is in progress.
    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StInFrame = 1'b1
    } feeder_state_e;

    typedef struct packed {
        logic [MacDataW-1:0] a;
        logic [MacDataW-1:0] b;
        logic                last;
    } operand_pair_t;

endpackage

// File: rtl/mac_feeder_fifo.sv
// Operand-pair FIFO for the MAC feeder. Pointers carry one extra wrap bit so
// that occupancy is a plain subtraction and full/empty need no extra state.
// Writes while full and reads while empty are ignored; flush empties it.
module mac_feeder_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   level_o
);

    localparam logic [AddrW:0] FullLevel = (AddrW + 1)'(Depth);
    localparam logic [AddrW:0] PtrOne    = 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == FullLevel);
    assign empty_o = (level_o == '0);
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

    // Full is taken from the registered pointers: a same-cycle read never frees a slot for a write.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Pointer next-state, flush has priority over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// MAC operand feeder: buffers (A,B) operand pairs and issues them to the MAC
// over valid/ready, tagging first/last beats and counting completed frames.
// Optional build macro MAC_FEEDER_STATS_EN adds beat and stall counters.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DataW = MacDataW,
    parameter int unsigned Depth = MacDepth,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [DataW-1:0] wr_a_i,
    input  logic [DataW-1:0] wr_b_i,
    input  logic             wr_last_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   level_o,
    output logic             ovf_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [DataW-1:0] op_a_o,
    output logic [DataW-1:0] op_b_o,
    output logic             op_first_o,
    output logic             op_last_o,
    output logic             frame_done_o,
    output logic [15:0]      frame_cnt_o
`ifdef MAC_FEEDER_STATS_EN
    ,
    output logic [31:0]      beat_cnt_o,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int unsigned PairW = 2 * DataW + 1;

    logic [PairW-1:0] head;
    logic [DataW-1:0] head_a;
    logic [DataW-1:0] head_b;
    logic             head_last;
    logic             fifo_empty;
    logic             fifo_full;
    logic             load;
    logic             handshake;

    feeder_state_e    state_q;
    logic             op_valid_q;
    logic [DataW-1:0] op_a_q;
    logic [DataW-1:0] op_b_q;
    logic             op_first_q;
    logic             op_last_q;
    logic             ovf_q;
    logic             frame_done_q;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    mac_feeder_fifo #(
        .Width (PairW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (wr_en_i),
        .wdata_i ({wr_a_i, wr_b_i, wr_last_i}),
        .pop_i   (load),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign head_a    = head[PairW-1 -: DataW];
    assign head_b    = head[DataW -: DataW];
    assign head_last = head[0];

    // Refill the output stage whenever it is free or being drained this cycle.
    assign load      = (!op_valid_q || op_ready_i) && !fifo_empty && !flush_i;
    assign handshake = op_valid_q && op_ready_i;

    // Frame FSM and output register; flush drops the staged beat and restarts framing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_first_q <= 1'b0;
            op_last_q  <= 1'b0;
        end else if (flush_i) begin
            state_q    <= StIdle;
            op_valid_q <= 1'b0;
        end else if (load) begin
            op_valid_q <= 1'b1;
            op_a_q     <= head_a;
            op_b_q     <= head_b;
            op_first_q <= (state_q == StIdle);
            op_last_q  <= head_last;
            state_q    <= head_last ? StIdle : StInFrame;
        end else if (op_ready_i) begin
            op_valid_q <= 1'b0;
        end
    end

    // Frame counter next-state: bump once per completed last-beat handshake.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (handshake && op_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Sticky overflow and frame-completion tracking; both survive flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            if (wr_en_i && fifo_full && !flush_i) ovf_q <= 1'b1;
            frame_done_q <= handshake && op_last_q;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef MAC_FEEDER_STATS_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] stall_cnt_q;

    // Beat and stall statistics; free-running, wrap, ignore flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (handshake)                beat_cnt_q  <= beat_cnt_q + 32'd1;
            if (op_valid_q && !op_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign beat_cnt_o  = beat_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign full_o       = fifo_full;
    assign empty_o      = fifo_empty;
    assign ovf_o        = ovf_q;
    assign op_valid_o   = op_valid_q;
    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign op_first_o   = op_first_q;
    assign op_last_o    = op_last_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: a queue-based reference model stepped on every
// clock edge, a per-cycle compare process, and directed scenarios with a few
// hand-computed literal expectations.
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int Depth = 8;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_a;
    logic [15:0] wr_b;
    logic        wr_last;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        ovf;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_first;
    logic        op_last;
    logic        frame_done;
    logic [15:0] frame_cnt;
`ifdef MAC_FEEDER_STATS_EN
    logic [31:0] beat_cnt;
    logic [31:0] stall_cnt;
`endif

    mac_operand_feeder dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .wr_en_i      (wr_en),
        .wr_a_i       (wr_a),
        .wr_b_i       (wr_b),
        .wr_last_i    (wr_last),
        .full_o       (full),
        .empty_o      (empty),
        .level_o      (level),
        .ovf_o        (ovf),
        .op_valid_o   (op_valid),
        .op_ready_i   (op_ready),
        .op_a_o       (op_a),
        .op_b_o       (op_b),
        .op_first_o   (op_first),
        .op_last_o    (op_last),
        .frame_done_o (frame_done),
        .frame_cnt_o  (frame_cnt)
`ifdef MAC_FEEDER_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: queued pairs plus the beat presented to the MAC.
    operand_pair_t mq[$];
    logic          m_valid, m_first, m_last;
    logic [15:0]   m_a, m_b;
    bit            m_inframe;
    logic          m_fdone;
    logic [15:0]   m_fcnt;
    logic          m_ovf;
    logic [31:0]   m_beats, m_stalls;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 0; m_first = 0; m_last = 0; m_a = 0; m_b = 0;
            m_inframe = 0; m_fdone = 0; m_fcnt = 0; m_ovf = 0;
            m_beats = 0; m_stalls = 0;
        end else begin
            automatic int  sz = mq.size();
            automatic bit  hs = m_valid && op_ready;
            automatic bit  ld;
            automatic operand_pair_t p;
            m_fdone = hs && m_last;
            if (hs && m_last) m_fcnt = m_fcnt + 16'd1;
            if (hs) m_beats = m_beats + 1;
            if (m_valid && !op_ready) m_stalls = m_stalls + 1;
            if (flush) begin
                mq.delete();
                m_valid   = 0;
                m_inframe = 0;
            end else begin
                ld = (!m_valid || op_ready) && sz > 0;
                if (wr_en && sz == Depth) m_ovf = 1;
                if (ld) begin
                    p = mq.pop_front();
                    m_a = p.a; m_b = p.b; m_last = p.last;
                    m_first   = !m_inframe;
                    m_inframe = !p.last;
                    m_valid   = 1;
                end else if (op_ready) begin
                    m_valid = 0;
                end
                if (wr_en && sz < Depth) begin
                    p.a = wr_a; p.b = wr_b; p.last = wr_last;
                    mq.push_back(p);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == Depth));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("op_valid", 32'(op_valid), 32'(m_valid));
        chk("frame_done", 32'(frame_done), 32'(m_fdone));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        if (m_valid) begin
            chk("op_a", 32'(op_a), 32'(m_a));
            chk("op_b", 32'(op_b), 32'(m_b));
            chk("op_first", 32'(op_first), 32'(m_first));
            chk("op_last", 32'(op_last), 32'(m_last));
        end
`ifdef MAC_FEEDER_STATS_EN
        chk("beat_cnt", beat_cnt, m_beats);
        chk("stall_cnt", stall_cnt, m_stalls);
`endif
    end

    // Apply one cycle of inputs across the next rising edge.
    task automatic drive(input bit w, input logic [15:0] a, input logic [15:0] b,
                         input bit l, input bit r, input bit f);
        wr_en = w; wr_a = a; wr_b = b; wr_last = l; op_ready = r; flush = f;
        @(negedge clk);
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) drive(0, 16'd0, 16'd0, 0, r, 0);
    endtask

    task automatic do_reset();
        wr_en = 0; wr_a = 0; wr_b = 0; wr_last = 0; op_ready = 0; flush = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1;
        #1;
        do_reset();

        // Two-beat frame, ready held high.
        drive(1, 16'd3, 16'd5, 0, 1, 0);
        chk("t2_lat_valid0", 32'(op_valid), 32'd0);
        drive(1, 16'd7, 16'd9, 1, 1, 0);
        chk("t2_b0_valid", 32'(op_valid), 32'd1);
        chk("t2_b0_a", 32'(op_a), 32'd3);
        chk("t2_b0_first", 32'(op_first), 32'd1);
        idle(1, 1);
        chk("t2_b1_a", 32'(op_a), 32'd7);
        chk("t2_b1_last", 32'(op_last), 32'd1);
        chk("t2_b1_first", 32'(op_first), 32'd0);
        idle(1, 1);
        chk("t2_done", 32'(frame_done), 32'd1);
        chk("t2_cnt", 32'(frame_cnt), 32'd1);
        idle(1, 2);

        // Fill with MAC stalled: one beat parks in the output stage, eight in the FIFO.
        for (int i = 0; i < 9; i++)
            drive(1, 16'(10 + i), 16'(20 + i), i == 8, 0, 0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_ovf0", 32'(ovf), 32'd0);
        chk("t3_head_a", 32'(op_a), 32'd10);
        drive(1, 16'hdead, 16'hbeef, 0, 0, 0);
        chk("t3_ovf1", 32'(ovf), 32'd1);
        chk("t3_level_kept", 32'(level), 32'd8);
        idle(1, 12);
        chk("t3_cnt", 32'(frame_cnt), 32'd2);

        // Ready toggling each cycle over a 20-beat frame.
        begin
            automatic int nb = 0;
            for (int i = 0; i < 40; i++) begin
                if (i % 2 == 0 && nb < 20) begin
                    drive(1, 16'(100 + nb), 16'(200 + nb), nb == 19, i % 2 == 1, 0);
                    nb++;
                end else begin
                    drive(0, 16'd0, 16'd0, 0, i % 2 == 1, 0);
                end
            end
        end
        idle(1, 6);
        chk("t4_cnt", 32'(frame_cnt), 32'd3);

        // Flush mid-frame with four pairs queued.
        for (int i = 0; i < 5; i++) drive(1, 16'(50 + i), 16'(60 + i), 0, 0, 0);
        chk("t5_level_pre", 32'(level), 32'd4);
        drive(0, 16'd0, 16'd0, 0, 0, 1);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_valid", 32'(op_valid), 32'd0);
        chk("t5_cnt_kept", 32'(frame_cnt), 32'd3);
        drive(1, 16'd99, 16'd98, 1, 1, 0);
        idle(1, 1);
        chk("t5_first", 32'(op_first), 32'd1);
        chk("t5_a", 32'(op_a), 32'd99);
        idle(1, 1);
        chk("t5_cnt", 32'(frame_cnt), 32'd4);
        idle(1, 2);

        // Asynchronous reset while streaming.
        for (int i = 0; i < 4; i++) drive(1, 16'(70 + i), 16'(80 + i), 0, 1, 0);
        #2;
        rst_n = 0;
        wr_en = 0; op_ready = 0;
        #1;
        chk("t1_valid", 32'(op_valid), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_level", 32'(level), 32'd0);
        chk("t1_cnt", 32'(frame_cnt), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);

`ifdef MAC_FEEDER_STATS_EN
        // Ten beats with four stall cycles.
        for (int i = 0; i < 10; i++)
            drive(1, 16'(30 + i), 16'(40 + i), i == 9, i >= 6, 0);
        idle(1, 12);
        chk("t6_beats", beat_cnt, 32'd10);
        chk("t6_stalls", stall_cnt, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
